// File: rtl/lv_bist_pkg.sv
// Shared types and helpers for the LV-side BIST sequencer.
package lv_bist_pkg;

    // Core clock cycles per microsecond, as used across the LV domain.
    localparam int COM_CLK_M = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ABIST = 2'b01,
        ST_LBIST = 2'b10,
        ST_END   = 2'b11
    } bist_st_e;

    typedef enum logic [1:0] {
        BIST_OK    = 2'b00,
        BIST_AFAIL = 2'b01,
        BIST_LFAIL = 2'b10,
        BIST_TMO   = 2'b11
    } bist_code_e;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lv_bist_tmr.sv
// Phase timer: clear-on-entry saturating up-counter, flags when it equals the limit.
// Zero-latency compare on the registered count; no backpressure.
module lv_bist_tmr #(
    parameter int W = 14
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         clr_i,
    input  logic [W-1:0] lim_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Holding at all-ones keeps a stuck phase from wrapping back under the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == lim_i);

endmodule

// File: rtl/lv_bist_seq.sv
// LV BIST sequencer: runs analog then logic BIST under timeouts, reports pass/fail + cause.
// Outputs registered, one cycle after each decision; no backpressure, requests outside IDLE are dropped.
module lv_bist_seq
    import lv_bist_pkg::*;
#(
    parameter int CLK_M       = COM_CLK_M,
    parameter int ABIST_TO_US = 100,
    parameter int LBIST_TO_US = 200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bist_req,
    input  logic       i_bist_abort,
    output logic       o_bist_en,
    input  logic       i_lbist_en,
    input  logic       i_lv_abist_fail,
    output logic       o_lbist_start,
    input  logic       i_lbist_done,
    input  logic       i_lbist_fail,
    output logic       o_bist_busy,
    output logic       o_bist_done,
    output logic       o_bist_fail,
    output logic [1:0] o_bist_code
);

    localparam int ABIST_TO_CYC = ABIST_TO_US * CLK_M;
    localparam int LBIST_TO_CYC = LBIST_TO_US * CLK_M;
    localparam int TMR_W        = $clog2(max_i(ABIST_TO_CYC, LBIST_TO_CYC) + 1);

    localparam logic [TMR_W-1:0] A_LIM = TMR_W'(ABIST_TO_CYC - 1);
    localparam logic [TMR_W-1:0] L_LIM = TMR_W'(LBIST_TO_CYC - 1);

    bist_st_e         st_q;
    bist_code_e       code_q;
    logic             bist_en_q;
    logic             lbist_start_q;
    logic             busy_q;
    logic             done_q;
    logic             fail_q;

    logic             tmr_clr;
    logic [TMR_W-1:0] tmr_lim;
    logic             tmr_hit;

    // Timer sits at zero outside the phases and restarts on the ABIST->LBIST handover.
    assign tmr_clr = (st_q == ST_IDLE) || (st_q == ST_END) ||
                     ((st_q == ST_ABIST) && i_lbist_en);
    assign tmr_lim = (st_q == ST_LBIST) ? L_LIM : A_LIM;

    lv_bist_tmr #(
        .W(TMR_W)
    ) u_tmr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .clr_i  (tmr_clr),
        .lim_i  (tmr_lim),
        .hit_o  (tmr_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q          <= ST_IDLE;
            code_q        <= BIST_OK;
            bist_en_q     <= 1'b0;
            lbist_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (i_bist_req) begin
                        st_q      <= ST_ABIST;
                        bist_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        code_q    <= BIST_OK;
                        fail_q    <= 1'b0;
                    end
                end
                ST_ABIST: begin
                    if (i_bist_abort) begin
                        st_q      <= ST_IDLE;
                        bist_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        code_q    <= BIST_OK;
                        fail_q    <= 1'b0;
                    end else if (i_lv_abist_fail) begin
                        st_q      <= ST_END;
                        bist_en_q <= 1'b0;
                        done_q    <= 1'b1;
                        code_q    <= BIST_AFAIL;
                        fail_q    <= 1'b1;
                    end else if (i_lbist_en) begin
                        st_q          <= ST_LBIST;
                        lbist_start_q <= 1'b1;
                    end else if (tmr_hit) begin
                        st_q      <= ST_END;
                        bist_en_q <= 1'b0;
                        done_q    <= 1'b1;
                        code_q    <= BIST_TMO;
                        fail_q    <= 1'b1;
                    end
                end
                ST_LBIST: begin
                    if (i_bist_abort) begin
                        st_q          <= ST_IDLE;
                        bist_en_q     <= 1'b0;
                        lbist_start_q <= 1'b0;
                        busy_q        <= 1'b0;
                        code_q        <= BIST_OK;
                        fail_q        <= 1'b0;
                    end else if (i_lbist_done || tmr_hit) begin
                        st_q          <= ST_END;
                        bist_en_q     <= 1'b0;
                        lbist_start_q <= 1'b0;
                        done_q        <= 1'b1;
                        if (i_lbist_done) begin
                            code_q <= i_lbist_fail ? BIST_LFAIL : BIST_OK;
                            fail_q <= i_lbist_fail;
                        end else begin
                            code_q <= BIST_TMO;
                            fail_q <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    st_q   <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    st_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_bist_en     = bist_en_q;
    assign o_lbist_start = lbist_start_q;
    assign o_bist_busy   = busy_q;
    assign o_bist_done   = done_q;
    assign o_bist_fail   = fail_q;
    assign o_bist_code   = code_q;

endmodule

// File: tb/tb_lv_bist_seq.sv
// Randomized bench for lv_bist_seq against a phase-window model of each BIST run.
module tb_lv_bist_seq;
    import lv_bist_pkg::*;

    localparam int ATO = 100 * 48;
    localparam int LTO = 200 * 48;

    // a_kind: 0 none, 1 lbist_en, 2 abist fail, 3 fail+lbist_en, 4 abort
    // l_kind: 0 none, 1 lbist_done, 2 abort
    localparam int AK_NONE = 0, AK_EN = 1, AK_FAIL = 2, AK_BOTH = 3, AK_ABORT = 4;
    localparam int LK_NONE = 0, LK_DONE = 1, LK_ABORT = 2;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_bist_req = 1'b0;
    logic       i_bist_abort = 1'b0;
    logic       i_lbist_en = 1'b0;
    logic       i_lv_abist_fail = 1'b0;
    logic       i_lbist_done = 1'b0;
    logic       i_lbist_fail = 1'b0;
    logic       o_bist_en;
    logic       o_lbist_start;
    logic       o_bist_busy;
    logic       o_bist_done;
    logic       o_bist_fail;
    logic [1:0] o_bist_code;

    int n_vec = 0;
    int n_err = 0;

    bit         held_fail = 1'b0;
    logic [1:0] held_code = 2'b00;

    lv_bist_seq dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_bist_req     (i_bist_req),
        .i_bist_abort   (i_bist_abort),
        .o_bist_en      (o_bist_en),
        .i_lbist_en     (i_lbist_en),
        .i_lv_abist_fail(i_lv_abist_fail),
        .o_lbist_start  (o_lbist_start),
        .i_lbist_done   (i_lbist_done),
        .i_lbist_fail   (i_lbist_fail),
        .o_bist_busy    (o_bist_busy),
        .o_bist_done    (o_bist_done),
        .o_bist_fail    (o_bist_fail),
        .o_bist_code    (o_bist_code)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input bit en, input bit ls, input bit done,
                            input bit busy, input bit fail, input logic [1:0] code);
        chk({tag, ".bist_en"},     o_bist_en,     en);
        chk({tag, ".lbist_start"}, o_lbist_start, ls);
        chk({tag, ".done"},        o_bist_done,   done);
        chk({tag, ".busy"},        o_bist_busy,   busy);
        chk({tag, ".fail"},        o_bist_fail,   fail);
        chk({tag, ".code"},        o_bist_code,   code);
    endtask

    task automatic drive_idle();
        i_bist_req      = 1'b0;
        i_bist_abort    = 1'b0;
        i_lbist_en      = 1'b0;
        i_lv_abist_fail = 1'b0;
        i_lbist_done    = 1'b0;
        i_lbist_fail    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, held_fail, held_code);
        end
    endtask

    // One request; outcome derived from when each phase event lands relative to its timeout.
    task automatic run_txn(input int a_evt, input int a_kind, input int l_evt,
                           input int l_kind, input bit l_fail, input bit rereq);
        int         la, ll, t_end;
        bit         a_hit, l_hit, to_lbist, aborted, efail;
        logic [1:0] ecode;

        a_hit    = (a_kind != AK_NONE) && (a_evt < ATO);
        la       = a_hit ? a_evt + 1 : ATO;
        to_lbist = a_hit && (a_kind == AK_EN);
        aborted  = a_hit && (a_kind == AK_ABORT);
        ll       = 0;
        if (!a_hit)                    ecode = 2'b11;
        else if (a_kind == AK_ABORT)   ecode = 2'b00;
        else if (a_kind == AK_EN)      ecode = 2'b00;
        else                           ecode = 2'b01;
        if (to_lbist) begin
            l_hit   = (l_kind != LK_NONE) && (l_evt < LTO);
            ll      = l_hit ? l_evt + 1 : LTO;
            aborted = l_hit && (l_kind == LK_ABORT);
            if (!l_hit)                   ecode = 2'b11;
            else if (l_kind == LK_ABORT)  ecode = 2'b00;
            else                          ecode = l_fail ? 2'b10 : 2'b00;
        end
        efail = (ecode != 2'b00);
        t_end = la + ll;

        @(negedge i_clk);
        i_bist_req = 1'b1;
        for (int t = 0; t <= t_end + 1; t++) begin
            @(negedge i_clk);
            if (t < la)
                chk_outs("abist", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
            else if (t < t_end)
                chk_outs("lbist", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
            else if (t == t_end && !aborted)
                chk_outs("end", 1'b0, 1'b0, 1'b1, 1'b1, efail, ecode);
            else if (aborted)
                chk_outs("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            else
                chk_outs("post_idle", 1'b0, 1'b0, 1'b0, 1'b0, efail, ecode);

            i_bist_req = rereq && (aborted ? (t < t_end) : (t <= t_end)) &&
                         ($urandom_range(0, 3) == 0);
            i_lbist_en = (t < t_end) &&
                         (((t < la) && (a_kind == AK_EN || a_kind == AK_BOTH) && (t >= a_evt)) ||
                          ((t >= la) && to_lbist));
            i_lv_abist_fail = (t < la) && (a_kind == AK_FAIL || a_kind == AK_BOTH) && (t >= a_evt);
            i_bist_abort = ((t < la) && (a_kind == AK_ABORT) && (t >= a_evt)) ||
                           (to_lbist && (t >= la) && (t < t_end) && (l_kind == LK_ABORT) &&
                            (t - la >= l_evt));
            i_lbist_done = to_lbist && (t >= la) && (t < t_end) && (l_kind == LK_DONE) &&
                           (t - la == l_evt);
            i_lbist_fail = i_lbist_done ? l_fail : 1'($urandom_range(0, 1));
            if (t == t_end + 1) drive_idle();
        end
        held_fail = aborted ? 1'b0 : efail;
        held_code = aborted ? 2'b00 : ecode;
    endtask

    task automatic reset_mid_lbist();
        @(negedge i_clk);
        i_bist_req = 1'b1;
        @(negedge i_clk);
        i_bist_req = 1'b0;
        i_lbist_en = 1'b1;
        repeat (20) @(negedge i_clk);
        chk_outs("pre_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        #2 i_rst_n = 1'b0;
        #1 chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge i_clk);
        drive_idle();
        i_rst_n   = 1'b1;
        held_fail = 1'b0;
        held_code = 2'b00;
        idle_cycles(3);
    endtask

    initial begin
        drive_idle();
        #1 chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle_cycles(2);

        // pass path, handover at 3362, logic done at 500
        run_txn(3362, AK_EN, 500, LK_DONE, 1'b0, 1'b1);
        idle_cycles(3);
        // analog fail and handover in the same cycle
        run_txn($urandom_range(0, 200), AK_BOTH, 0, LK_NONE, 1'b0, 1'b1);
        idle_cycles(2);
        // logic fail, held through 100 idle cycles, cleared by next request
        run_txn($urandom_range(0, 200), AK_EN, $urandom_range(0, 200), LK_DONE, 1'b1, 1'b0);
        idle_cycles(100);
        // analog timeout
        run_txn(0, AK_NONE, 0, LK_NONE, 1'b0, 1'b1);
        idle_cycles(2);
        // logic timeout
        run_txn($urandom_range(0, 100), AK_EN, 0, LK_NONE, 1'b0, 1'b0);
        idle_cycles(2);
        // events exactly on the timeout cycle win
        run_txn(ATO - 1, AK_EN, 10, LK_DONE, 1'b0, 1'b0);
        idle_cycles(2);
        run_txn(5, AK_EN, LTO - 1, LK_DONE, 1'b1, 1'b0);
        idle_cycles(2);
        // aborts
        run_txn($urandom_range(0, 100), AK_ABORT, 0, LK_NONE, 1'b0, 1'b1);
        idle_cycles(2);
        run_txn($urandom_range(0, 100), AK_EN, $urandom_range(0, 100), LK_ABORT, 1'b0, 1'b1);
        idle_cycles(2);
        run_txn(20, AK_FAIL, 0, LK_NONE, 1'b0, 1'b0);
        idle_cycles(2);

        for (int i = 0; i < 12; i++) begin
            run_txn($urandom_range(0, 300), $urandom_range(1, 4), $urandom_range(0, 300),
                    $urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(1, 5));
        end

        reset_mid_lbist();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
